// File: rtl/audio_i2s_port_if.sv
// audio_i2s_port_if
//   Groups the codec pins and the parallel ADC/DAC sample interface of the
//   audio serial port into one bundle.
//   master : codec/system side (drives the codec pins and the DAC words, observes the results)
//   slave  : the audio_i2s_port itself
//   Codec pins   : AC_BCLK, AC_LRCLK, AC_ADC_SDATA (to port), AC_DAC_SDATA (from port)
//   ADC side     : ADC_LEFT, ADC_RIGHT, ADC_VALID (from port)
//   DAC side     : DAC_LEFT, DAC_RIGHT, DAC_VALID (to port), DAC_READY, UNDERRUN (from port)
interface audio_i2s_port_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic                    AC_BCLK;
  logic                    AC_LRCLK;
  logic                    AC_ADC_SDATA;
  logic                    AC_DAC_SDATA;
  logic [SAMPLE_WIDTH-1:0] ADC_LEFT;
  logic [SAMPLE_WIDTH-1:0] ADC_RIGHT;
  logic                    ADC_VALID;
  logic [SAMPLE_WIDTH-1:0] DAC_LEFT;
  logic [SAMPLE_WIDTH-1:0] DAC_RIGHT;
  logic                    DAC_VALID;
  logic                    DAC_READY;
  logic                    UNDERRUN;

  modport master (
    output AC_BCLK, AC_LRCLK, AC_ADC_SDATA, DAC_LEFT, DAC_RIGHT, DAC_VALID,
    input  AC_DAC_SDATA, ADC_LEFT, ADC_RIGHT, ADC_VALID, DAC_READY, UNDERRUN
  );

  modport slave (
    input  AC_BCLK, AC_LRCLK, AC_ADC_SDATA, DAC_LEFT, DAC_RIGHT, DAC_VALID,
    output AC_DAC_SDATA, ADC_LEFT, ADC_RIGHT, ADC_VALID, DAC_READY, UNDERRUN
  );
endinterface

// File: rtl/audio_i2s_port.sv
// audio_i2s_port
//   I2S serial port for an audio codec that is bus master. BCLK, LRCLK and the
//   ADC data line are asynchronous to CLK_48; they are synchronised and BCLK
//   edges are detected in the CLK_48 domain. Incoming stereo frames are
//   deserialised into ADC_LEFT/ADC_RIGHT; DAC word pairs offered on a
//   valid/ready handshake are serialised MSB-first onto AC_DAC_SDATA.
//   Ports:
//     CLK_48  - 48 MHz system clock, the only clock
//     RESET   - synchronous active-high reset
//     LOCKED  - clock-stable flag, LOCKED=0 behaves exactly like RESET=1
//     bus     - audio_i2s_port_if.slave: codec pins plus ADC/DAC sample interface
module audio_i2s_port #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_BITS    = 32
) (
  input  logic              CLK_48,
  input  logic              RESET,
  input  logic              LOCKED,
  audio_i2s_port_if.slave   bus
);

  localparam int CNT_W = $clog2(SLOT_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SW_CNT  = CNT_W'(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] SW_LAST = CNT_W'(SAMPLE_WIDTH - 1);

  typedef enum logic [1:0] {
    UNSYNCED = 2'd0,
    LEFT     = 2'd1,
    RIGHT    = 2'd2
  } state_t;

  logic srst;
  assign srst = RESET | ~LOCKED;

  // ---------------------------------------------------------------------------
  // Input synchronisers: bit 0 = BCLK, bit 1 = LRCLK, bit 2 = ADC data.
  // These are pure pipelines and carry no state worth resetting.
  // ---------------------------------------------------------------------------
  logic [2:0] async_in;
  logic [2:0] sync_in;
  assign async_in = {bus.AC_ADC_SDATA, bus.AC_LRCLK, bus.AC_BCLK};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge CLK_48) begin
        meta_reg <= async_in[gi];
        sync_reg <= meta_reg;
      end
      assign sync_in[gi] = sync_reg;
    end
  endgenerate

  logic bclk_sync, lr_sync, sdata_sync;
  logic bclk_d_reg;
  assign bclk_sync  = sync_in[0];
  assign lr_sync    = sync_in[1];
  assign sdata_sync = sync_in[2];

  always_ff @(posedge CLK_48) begin
    bclk_d_reg <= bclk_sync;
  end

  // LRCLK and data only move on BCLK falls, so at a rise strobe they have been
  // stable for half a BCLK period and need no extra alignment stage.
  logic rise, fall;
  assign rise = bclk_sync & ~bclk_d_reg;
  assign fall = ~bclk_sync & bclk_d_reg;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t                  state_reg, state_next;
  logic                    lr_prev_reg;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic [SAMPLE_WIDTH-1:0] adc_shift_reg;
  logic [SAMPLE_WIDTH-1:0] left_tmp_reg;
  logic                    left_ok_reg;
  logic [SAMPLE_WIDTH-1:0] adc_left_reg, adc_right_reg;
  logic                    adc_valid_reg;
  logic [SAMPLE_WIDTH-1:0] hold_l_reg, hold_r_reg;
  logic                    hold_full_reg, hold_full_next;
  logic                    dac_ready_reg;
  logic [SAMPLE_WIDTH-1:0] dac_sh_reg, dac_r_reg;
  logic                    dac_sdata_reg;
  logic                    underrun_reg;

  logic                    lr_change, frame_start, right_start, load;
  logic [SAMPLE_WIDTH-1:0] adc_shift_next;

  assign adc_shift_next = {adc_shift_reg[SAMPLE_WIDTH-2:0], sdata_sync};
  assign load           = bus.DAC_VALID & dac_ready_reg;

  // Slot tracking FSM. A 1->0 LRCLK change always starts a left slot (and is
  // how we leave UNSYNCED); a 0->1 change only matters once synchronised,
  // which is what drops a right slot seen before any left slot.
  always_comb begin
    state_next  = state_reg;
    lr_change   = 1'b0;
    frame_start = 1'b0;
    right_start = 1'b0;
    if (rise && (lr_sync != lr_prev_reg)) begin
      lr_change = 1'b1;
      if (!lr_sync) begin
        state_next  = LEFT;
        frame_start = 1'b1;
      end else if (state_reg != UNSYNCED) begin
        state_next  = RIGHT;
        right_start = 1'b1;
      end
    end
  end

  // Holding register occupancy. A load coinciding with a frame start lands
  // in the (then empty) holding register and waits for the next frame.
  always_comb begin
    hold_full_next = hold_full_reg;
    if (frame_start && hold_full_reg) begin
      hold_full_next = 1'b0;
    end
    if (load) begin
      hold_full_next = 1'b1;
    end
  end

  always_ff @(posedge CLK_48) begin
    if (srst) begin
      state_reg     <= UNSYNCED;
      lr_prev_reg   <= 1'b0;
      bit_cnt_reg   <= '0;
      adc_shift_reg <= '0;
      left_tmp_reg  <= '0;
      left_ok_reg   <= 1'b0;
      adc_left_reg  <= '0;
      adc_right_reg <= '0;
      adc_valid_reg <= 1'b0;
      hold_l_reg    <= '0;
      hold_r_reg    <= '0;
      hold_full_reg <= 1'b0;
      dac_ready_reg <= 1'b0;
      dac_sh_reg    <= '0;
      dac_r_reg     <= '0;
      dac_sdata_reg <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      adc_valid_reg <= 1'b0;
      underrun_reg  <= 1'b0;
      hold_full_reg <= hold_full_next;
      dac_ready_reg <= ~hold_full_next;

      // Bit counter: 0 on the I2S delay bit, then data bit n has count n.
      if (rise) begin
        lr_prev_reg <= lr_sync;
        if (lr_change) begin
          bit_cnt_reg <= '0;
        end else if (bit_cnt_reg != CNT_MAX) begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end

      // ADC capture. A left word only counts once all its bits arrived, so a
      // truncated left slot suppresses the pair of that frame.
      if (frame_start) begin
        left_ok_reg <= 1'b0;
      end else if (rise && !lr_change && (state_reg != UNSYNCED) && (bit_cnt_reg < SW_CNT)) begin
        adc_shift_reg <= adc_shift_next;
        if (bit_cnt_reg == SW_LAST) begin
          if (state_reg == LEFT) begin
            left_tmp_reg <= adc_shift_next;
            left_ok_reg  <= 1'b1;
          end else if (left_ok_reg) begin
            adc_left_reg  <= left_tmp_reg;
            adc_right_reg <= adc_shift_next;
            adc_valid_reg <= 1'b1;
            left_ok_reg   <= 1'b0;
          end
        end
      end

      if (load) begin
        hold_l_reg <= bus.DAC_LEFT;
        hold_r_reg <= bus.DAC_RIGHT;
      end

      // DAC serialiser: the left word is loaded at the frame-start rise and
      // the right word at the rise entering RIGHT; each following fall puts
      // the next bit on the pin so the codec samples it on the next rise.
      if (frame_start) begin
        if (hold_full_reg) begin
          dac_sh_reg <= hold_l_reg;
          dac_r_reg  <= hold_r_reg;
        end else begin
          dac_sh_reg   <= '0;
          dac_r_reg    <= '0;
          underrun_reg <= 1'b1;
        end
      end else if (right_start) begin
        dac_sh_reg <= dac_r_reg;
      end else if (fall) begin
        if ((state_reg != UNSYNCED) && (bit_cnt_reg < SW_CNT)) begin
          dac_sdata_reg <= dac_sh_reg[SAMPLE_WIDTH-1];
          dac_sh_reg    <= {dac_sh_reg[SAMPLE_WIDTH-2:0], 1'b0};
        end else begin
          dac_sdata_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.AC_DAC_SDATA = dac_sdata_reg;
  assign bus.ADC_LEFT     = adc_left_reg;
  assign bus.ADC_RIGHT    = adc_right_reg;
  assign bus.ADC_VALID    = adc_valid_reg;
  assign bus.DAC_READY    = dac_ready_reg;
  assign bus.UNDERRUN     = underrun_reg;

endmodule

// File: tb/tb_audio_i2s_port.sv
// tb_audio_i2s_port
//   Directed bench for audio_i2s_port. A codec model drives BCLK = CLK_48/16
//   with 32-bit slots, changes LRCLK and ADC data on BCLK falls, and decodes
//   AC_DAC_SDATA on BCLK rises. One line is printed per played frame.
module tb_audio_i2s_port;
  localparam int SW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic locked;

  audio_i2s_port_if #(.SAMPLE_WIDTH(SW)) bus();

  audio_i2s_port #(.SAMPLE_WIDTH(SW), .SLOT_BITS(32)) dut (
    .CLK_48 (clk),
    .RESET  (reset),
    .LOCKED (locked),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Event monitor
  int            valid_cnt    = 0;
  int            underrun_cnt = 0;
  logic [SW-1:0] last_l       = '0;
  logic [SW-1:0] last_r       = '0;

  always @(negedge clk) begin
    if (bus.ADC_VALID) begin
      valid_cnt++;
      last_l = bus.ADC_LEFT;
      last_r = bus.ADC_RIGHT;
    end
    if (bus.UNDERRUN) underrun_cnt++;
  end

  // Results of the most recent frame and the reset snapshot
  logic [SW-1:0] rx_l, rx_r;
  logic          any_l, any_r;
  logic [SW-1:0] snap_adc_l;
  logic          snap_ready, snap_sdata, snap_valid;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One codec slot of nbits BCLK periods. Called and returns on a negedge.
  task automatic play_slot(input logic lr, input logic [SW-1:0] word, input int nbits,
                           input bit offer, input int unlock_bit,
                           output logic [SW-1:0] rx, output logic any_one);
    rx      = '0;
    any_one = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      bus.AC_BCLK = 1'b0;
      if (k == 0) bus.AC_LRCLK = lr;
      if (k >= 1 && k <= SW) bus.AC_ADC_SDATA = word[SW-k];
      else                   bus.AC_ADC_SDATA = 1'b0;
      if (k == unlock_bit) begin
        locked = 1'b0;
        repeat (3) @(negedge clk);
        snap_adc_l = bus.ADC_LEFT;
        snap_ready = bus.DAC_READY;
        snap_sdata = bus.AC_DAC_SDATA;
        snap_valid = bus.ADC_VALID;
        repeat (2) @(negedge clk);
        locked = 1'b1;
        repeat (3) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      any_one = any_one | bus.AC_DAC_SDATA;
      if (k >= 1 && k <= SW) rx = {rx[SW-2:0], bus.AC_DAC_SDATA};
      bus.AC_BCLK = 1'b1;
      if (offer && k == 0) begin
        // Timed so DAC_VALID is sampled on the edge that acts on this rise.
        repeat (2) @(negedge clk);
        bus.DAC_VALID = 1'b1;
        @(negedge clk);
        bus.DAC_VALID = 1'b0;
        repeat (5) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
    end
  endtask

  task automatic play_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input int lbits,
                            input bit offer, input int unlock_bit);
    play_slot(1'b0, l, lbits, offer, -1, rx_l, any_l);
    play_slot(1'b1, r, 32, 1'b0, unlock_bit, rx_r, any_r);
    $display("frame adc_l=%06h adc_r=%06h dac_l=%06h dac_r=%06h valid_total=%0d underrun_total=%0d",
             l, r, rx_l, rx_r, valid_cnt, underrun_cnt);
  endtask

  int   v0, u0;
  logic any_acc;
  logic [SW-1:0] dummy_rx;
  logic          dummy_any;

  initial begin
    reset            = 1'b1;
    locked           = 1'b1;
    bus.AC_BCLK      = 1'b1;
    bus.AC_LRCLK     = 1'b1;
    bus.AC_ADC_SDATA = 1'b0;
    bus.DAC_LEFT     = '0;
    bus.DAC_RIGHT    = '0;
    bus.DAC_VALID    = 1'b0;
    snap_adc_l = '1; snap_ready = 1'b1; snap_sdata = 1'b1; snap_valid = 1'b1;
    repeat (6) @(negedge clk);

    // Reset state
    check_eq("rst_adc_valid", 32'(bus.ADC_VALID), 32'd0);
    check_eq("rst_adc_left",  32'(bus.ADC_LEFT), 32'd0);
    check_eq("rst_adc_right", 32'(bus.ADC_RIGHT), 32'd0);
    check_eq("rst_dac_ready", 32'(bus.DAC_READY), 32'd0);
    check_eq("rst_underrun",  32'(bus.UNDERRUN), 32'd0);
    check_eq("rst_dac_sdata", 32'(bus.AC_DAC_SDATA), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(bus.DAC_READY), 32'd1);

    // 1: right-only slot ignored, then one ADC_VALID per frame
    play_slot(1'b1, 24'h0F1E2D, 32, 1'b0, -1, dummy_rx, dummy_any);
    check_eq("t1_partial_valid", 32'(valid_cnt), 32'd0);
    check_eq("t1_partial_underrun", 32'(underrun_cnt), 32'd0);
    for (int f = 0; f < 2; f++) begin
      v0 = valid_cnt;
      play_frame(24'hA5C3F0, 24'h0F1E2D, 32, 1'b0, -1);
      check_eq("t1_valid_count", 32'(valid_cnt - v0), 32'd1);
      check_eq("t1_adc_left", 32'(last_l), 32'h00A5C3F0);
      check_eq("t1_adc_right", 32'(last_r), 32'h000F1E2D);
    end

    // 2: DAC pair loaded ahead of the frame plays back unchanged
    bus.DAC_LEFT  = 24'h800001;
    bus.DAC_RIGHT = 24'h7FFFFE;
    bus.DAC_VALID = 1'b1;
    @(negedge clk);
    bus.DAC_VALID = 1'b0;
    check_eq("t2_ready_drop", 32'(bus.DAC_READY), 32'd0);
    @(negedge clk);
    check_eq("t2_ready_held", 32'(bus.DAC_READY), 32'd0);
    u0 = underrun_cnt;
    play_frame(24'h111111, 24'h222222, 32, 1'b0, -1);
    check_eq("t2_dac_left", 32'(rx_l), 32'h00800001);
    check_eq("t2_dac_right", 32'(rx_r), 32'h007FFFFE);
    check_eq("t2_underrun", 32'(underrun_cnt - u0), 32'd0);
    check_eq("t2_ready_back", 32'(bus.DAC_READY), 32'd1);
    check_eq("t2_adc_left", 32'(last_l), 32'h00111111);

    // 3: three starved frames
    u0 = underrun_cnt;
    any_acc = 1'b0;
    for (int f = 0; f < 3; f++) begin
      play_frame(24'h333333, 24'h444444, 32, 1'b0, -1);
      any_acc = any_acc | any_l | any_r;
    end
    check_eq("t3_underruns", 32'(underrun_cnt - u0), 32'd3);
    check_eq("t3_dac_zero", 32'(any_acc), 32'd0);

    // 4: DAC_VALID on the frame-start strobe cycle
    bus.DAC_LEFT  = 24'h123456;
    bus.DAC_RIGHT = 24'hABCDEF;
    u0 = underrun_cnt;
    play_frame(24'h555555, 24'h666666, 32, 1'b1, -1);
    check_eq("t4_underrun", 32'(underrun_cnt - u0), 32'd1);
    check_eq("t4_dac_left_zero", 32'(rx_l), 32'd0);
    check_eq("t4_dac_right_zero", 32'(rx_r), 32'd0);
    check_eq("t4_ready_full", 32'(bus.DAC_READY), 32'd0);
    u0 = underrun_cnt;
    play_frame(24'h777777, 24'h888888, 32, 1'b0, -1);
    check_eq("t4_next_dac_left", 32'(rx_l), 32'h00123456);
    check_eq("t4_next_dac_right", 32'(rx_r), 32'h00ABCDEF);
    check_eq("t4_next_underrun", 32'(underrun_cnt - u0), 32'd0);

    // 5: LOCKED low for 5 cycles mid right slot
    v0 = valid_cnt;
    play_frame(24'hDEAD01, 24'hBEEF02, 32, 1'b0, 12);
    check_eq("t5_snap_adc_left", 32'(snap_adc_l), 32'd0);
    check_eq("t5_snap_ready", 32'(snap_ready), 32'd0);
    check_eq("t5_snap_sdata", 32'(snap_sdata), 32'd0);
    check_eq("t5_snap_valid", 32'(snap_valid), 32'd0);
    check_eq("t5_no_valid", 32'(valid_cnt - v0), 32'd0);
    v0 = valid_cnt;
    play_frame(24'h13579B, 24'h2468AC, 32, 1'b0, -1);
    check_eq("t5_resume_count", 32'(valid_cnt - v0), 32'd1);
    check_eq("t5_resume_left", 32'(last_l), 32'h0013579B);
    check_eq("t5_resume_right", 32'(last_r), 32'h002468AC);

    // 6: left slot cut short after 10 data bits
    v0 = valid_cnt;
    play_frame(24'hFEDCBA, 24'h0A0B0C, 11, 1'b0, -1);
    check_eq("t6_trunc_no_valid", 32'(valid_cnt - v0), 32'd0);
    v0 = valid_cnt;
    play_frame(24'h654321, 24'h0ABCDE, 32, 1'b0, -1);
    check_eq("t6_next_count", 32'(valid_cnt - v0), 32'd1);
    check_eq("t6_next_left", 32'(last_l), 32'h00654321);
    check_eq("t6_next_right", 32'(last_r), 32'h000ABCDE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
